qe_speed_measure_unit: RTL

//  Parametrised successor to the single-channel QE speed FSM: one self-contained speed channel
//  (FSM + prescaled timing counter + averaging accumulator + direction capture).

---
 rtl/qe_pkg.sv | 23 ++
 rtl/qe_edge_detect.sv | 32 +++
 rtl/qe_speed_measure_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/qe_pkg.sv
// Shared types and constants for the quadrature-encoder speed channel.
// State encoding, direction polarity and the averaging-exponent clamp.
package qe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ARM   = 3'd2,
    ST_MEAS  = 3'd3,
    ST_ACC   = 3'd4,
    ST_AVG   = 3'd5,
    ST_LOAD  = 3'd6,
    ST_STALL = 3'd7
  } qe_meas_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic logic [2:0] clamp_avg(input logic [2:0] req, input logic [2:0] max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage

// File: rtl/qe_edge_detect.sv
// Two-flop synchroniser for an asynchronous encoder pin, followed by
// a previous-value register that yields single-clock rise/fall pulses.
module qe_edge_detect (
  input  logic clk,
  input  logic i_reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/qe_speed_measure_unit.sv
// One encoder speed channel: measures A high width or A period in prescaled
// ticks, optionally averages 2^N samples, and flags a stall on overflow.
module qe_speed_measure_unit
  import qe_pkg::*;
#(
  parameter int COUNT_W      = 24,
  parameter int MAX_LOG2_AVG = 4,
  parameter int PRESCALE_W   = 8
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_qe_a,
  input  logic                  i_qe_b,
  input  logic                  i_period_mode,
  input  logic [2:0]            i_avg_log2,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic [COUNT_W-1:0]    i_overflow_limit,
  output logic [COUNT_W-1:0]    o_speed,
  output logic                  o_direction,
  output logic                  o_speed_valid,
  output logic                  o_stalled,
  output logic                  o_busy
);

  localparam int ACC_W = COUNT_W + MAX_LOG2_AVG;
  localparam int SMP_W = MAX_LOG2_AVG + 1;
  localparam logic [2:0] AVG_MAX = 3'(MAX_LOG2_AVG);

  qe_meas_state_t r_state, r_state_next;

  logic w_a_sync, w_a_rise, w_a_fall;
  logic w_b_sync, w_b_rise_unused, w_b_fall_unused;

  logic                  r_mode;
  logic [2:0]            r_avg_log2;
  logic [PRESCALE_W-1:0] r_presc_reload;
  logic [PRESCALE_W-1:0] r_presc;
  logic [COUNT_W-1:0]    r_limit;
  logic [COUNT_W-1:0]    r_count;
  logic [COUNT_W-1:0]    r_sample;
  logic [COUNT_W-1:0]    r_result;
  logic [ACC_W-1:0]      r_acc;
  logic [SMP_W-1:0]      r_samples;
  logic                  r_dir_tmp;
  logic [COUNT_W-1:0]    r_speed;
  logic                  r_direction;
  logic                  r_speed_valid;
  logic                  r_stalled;

  logic                  w_tick;
  logic                  w_stall_hit;
  logic                  w_close;
  logic [COUNT_W-1:0]    w_count_inc;
  logic [2:0]            w_avg_req;

  qe_edge_detect u_edge_a (
    .clk    (clk),
    .i_reset(i_reset),
    .i_pin  (i_qe_a),
    .o_sync (w_a_sync),
    .o_rise (w_a_rise),
    .o_fall (w_a_fall)
  );

  qe_edge_detect u_edge_b (
    .clk    (clk),
    .i_reset(i_reset),
    .i_pin  (i_qe_b),
    .o_sync (w_b_sync),
    .o_rise (w_b_rise_unused),
    .o_fall (w_b_fall_unused)
  );

  assign w_tick      = (r_presc == '0);
  // Limit is checked before the increment, so the count can never wrap.
  assign w_stall_hit = w_tick && (r_count == r_limit);
  assign w_close     = r_mode ? w_a_rise : w_a_fall;
  assign w_count_inc = r_count + COUNT_W'(w_tick);
  assign w_avg_req   = clamp_avg(i_avg_log2, AVG_MAX);

  always_ff @(posedge clk) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    if (!i_enable) begin
      r_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  r_state_next = ST_INIT;
        ST_INIT:  r_state_next = ST_ARM;
        ST_ARM:   if (w_a_rise) r_state_next = ST_MEAS;
        ST_MEAS: begin
          if (w_stall_hit)  r_state_next = ST_STALL;
          else if (w_close) r_state_next = ST_ACC;
        end
        ST_ACC: begin
          if (r_samples == SMP_W'(1)) r_state_next = ST_AVG;
          else if (r_mode)            r_state_next = ST_MEAS;
          else                        r_state_next = ST_ARM;
        end
        ST_AVG:   r_state_next = ST_LOAD;
        ST_LOAD:  r_state_next = ST_INIT;
        ST_STALL: r_state_next = ST_INIT;
        default:  r_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_mode         <= 1'b0;
      r_avg_log2     <= '0;
      r_presc_reload <= '0;
      r_presc        <= '0;
      r_limit        <= '0;
      r_count        <= '0;
      r_sample       <= '0;
      r_result       <= '0;
      r_acc          <= '0;
      r_samples      <= '0;
      r_dir_tmp      <= DIR_FWD;
      r_speed        <= '0;
      r_direction    <= DIR_FWD;
      r_speed_valid  <= 1'b0;
      r_stalled      <= 1'b0;
    end else begin
      r_speed_valid <= 1'b0;
      if (r_state != ST_INIT) r_presc <= w_tick ? r_presc_reload : r_presc - 1'b1;
      case (r_state)
        ST_INIT: begin
          r_mode         <= i_period_mode;
          r_avg_log2     <= w_avg_req;
          r_presc_reload <= i_prescale;
          r_presc        <= i_prescale;
          r_limit        <= i_overflow_limit;
          r_count        <= '0;
          r_acc          <= '0;
          r_samples      <= SMP_W'(1) << w_avg_req;
        end
        ST_ARM: begin
          if (w_a_rise) begin
            r_count   <= '0;
            r_dir_tmp <= w_b_sync ? DIR_REV : DIR_FWD;
          end
        end
        ST_MEAS: begin
          if (!w_stall_hit) begin
            if (w_close) begin
              r_sample <= w_count_inc;
              // Period mode: the closing rise also opens the next period.
              if (r_mode) begin
                r_count   <= '0;
                r_dir_tmp <= w_b_sync ? DIR_REV : DIR_FWD;
              end else begin
                r_count <= w_count_inc;
              end
            end else begin
              r_count <= w_count_inc;
            end
          end
        end
        ST_ACC: begin
          r_acc     <= r_acc + ACC_W'(r_sample);
          r_samples <= r_samples - SMP_W'(1);
          if (r_mode && (r_count != r_limit)) r_count <= w_count_inc;
        end
        ST_AVG: r_result <= COUNT_W'(r_acc >> r_avg_log2);
        ST_LOAD: begin
          if (i_enable) begin
            r_speed       <= r_result;
            r_direction   <= r_dir_tmp;
            r_speed_valid <= 1'b1;
            r_stalled     <= 1'b0;
          end
        end
        ST_STALL: begin
          if (i_enable) begin
            r_speed       <= '1;
            r_speed_valid <= 1'b1;
            r_stalled     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_speed       = r_speed;
  assign o_direction   = r_direction;
  assign o_speed_valid = r_speed_valid;
  assign o_stalled     = r_stalled;
  assign o_busy        = (r_state != ST_IDLE);

endmodule
